rx_frame_sync: RTL and testbench

Frame synchroniser for the BPSK receive path, directly downstream of the preamble detector. Once `PD_flag` is asserted, it hunts the hard-decision bit stream for a 32-bit sync word, with a configurable Hamming-error tolerance. It then reads an 8-bit length field and emits the payload as bytes. At the end of a packet or on a hunt timeout it pulses `packet_done`, which drives the preamble detector's `disassert_PD` input and re-arms it.

---
 rtl/rx_frame_sync.sv | 168 ++++++++++++++++
 tb/tb_rx_frame_sync.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/rx_frame_sync.sv
// Frame synchroniser: hunts for a sync word after preamble detect, then de-frames length + payload bytes.
// Optional macro RX_FS_INVERT_EN adds an inverted-polarity sync comparator to resolve BPSK 180-degree ambiguity.
module rx_frame_sync #(
    parameter int                    SYNC_WIDTH    = 32,
    parameter logic [SYNC_WIDTH-1:0] SYNC_WORD     = 32'h1ACFFC1D,
    parameter int                    TIMEOUT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [3:0]               RX_FS_MAX_ERR,
    input  logic [TIMEOUT_WIDTH-1:0] RX_FS_TIMEOUT,
    input  logic                     BPSK,
    input  logic                     PD_flag,
    output logic                     sync_found,
    output logic                     inverted,
    output logic [7:0]               frame_len,
    output logic [7:0]               data_out,
    output logic                     data_valid,
    output logic                     packet_done,
    output logic                     frame_err
);

    typedef enum logic [2:0] {IDLE, HUNT, LEN, DATA, DONE} state_t;

    state_t                   state, state_nxt;
    logic [SYNC_WIDTH-1:0]    sreg, next_sreg;
    logic [TIMEOUT_WIDTH-1:0] to_cnt;
    logic [2:0]               bit_cnt;
    logic [7:0]               byte_cnt;
    logic [7:0]               byte_sh, sh_nxt;
    logic                     polarity;
    logic                     match_true, match_inv;
    logic                     sync_hit, timeout_hit, abort_hit, len_hit, byte_hit, done_hit;

    function automatic logic [5:0] popcount(input logic [SYNC_WIDTH-1:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < SYNC_WIDTH; i++) n = n + {5'd0, v[i]};
        return n;
    endfunction

    assign next_sreg  = {sreg[SYNC_WIDTH-2:0], BPSK};
    assign sh_nxt     = {byte_sh[6:0], BPSK ^ polarity};
    assign match_true = popcount(next_sreg ^ SYNC_WORD) <= {2'b00, RX_FS_MAX_ERR};

`ifdef RX_FS_INVERT_EN
    assign match_inv = popcount(next_sreg ^ ~SYNC_WORD) <= {2'b00, RX_FS_MAX_ERR};

    // Polarity is latched at sync acceptance; true polarity wins a tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            polarity <= 1'b0;
            inverted <= 1'b0;
        end else if (sync_hit) begin
            polarity <= !match_true;
            inverted <= !match_true;
        end
    end
`else
    assign match_inv = 1'b0;
    assign polarity  = 1'b0;
    assign inverted  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Priority inside each active state: abort, then sync match, then timeout.
    always_comb begin
        state_nxt   = state;
        sync_hit    = 1'b0;
        timeout_hit = 1'b0;
        abort_hit   = 1'b0;
        len_hit     = 1'b0;
        byte_hit    = 1'b0;
        done_hit    = 1'b0;
        case (state)
            IDLE: if (PD_flag) state_nxt = HUNT;
            HUNT: begin
                if (!PD_flag) begin
                    abort_hit = 1'b1;
                    state_nxt = IDLE;
                end else if (match_true || match_inv) begin
                    sync_hit  = 1'b1;
                    state_nxt = LEN;
                end else if ((RX_FS_TIMEOUT != '0) && (to_cnt == RX_FS_TIMEOUT)) begin
                    timeout_hit = 1'b1;
                    state_nxt   = DONE;
                end
            end
            LEN: begin
                if (!PD_flag) begin
                    abort_hit = 1'b1;
                    state_nxt = IDLE;
                end else if (bit_cnt == 3'd7) begin
                    len_hit   = 1'b1;
                    state_nxt = (sh_nxt == 8'd0) ? DONE : DATA;
                end
            end
            DATA: begin
                if (!PD_flag) begin
                    abort_hit = 1'b1;
                    state_nxt = IDLE;
                end else if (bit_cnt == 3'd7) begin
                    byte_hit = 1'b1;
                    if (byte_cnt + 8'd1 == frame_len) state_nxt = DONE;
                end
            end
            DONE: begin
                done_hit  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg        <= '0;
            to_cnt      <= '0;
            bit_cnt     <= '0;
            byte_cnt    <= '0;
            byte_sh     <= '0;
            frame_len   <= '0;
            data_out    <= '0;
            sync_found  <= 1'b0;
            data_valid  <= 1'b0;
            packet_done <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            sync_found  <= sync_hit;
            data_valid  <= byte_hit;
            packet_done <= done_hit;
            frame_err   <= abort_hit | timeout_hit;
            case (state)
                IDLE: begin
                    sreg     <= '0;
                    to_cnt   <= '0;
                    bit_cnt  <= '0;
                    byte_cnt <= '0;
                end
                HUNT: begin
                    sreg    <= next_sreg;
                    to_cnt  <= to_cnt + 1'b1;
                    bit_cnt <= '0;
                end
                LEN, DATA: begin
                    if (PD_flag) begin
                        byte_sh <= sh_nxt;
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    if (len_hit) begin
                        frame_len <= sh_nxt;
                        byte_cnt  <= '0;
                    end
                    if (byte_hit) begin
                        data_out <= sh_nxt;
                        byte_cnt <= byte_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rx_frame_sync.sv
// Scoreboard bench for rx_frame_sync: the driver queues expected pulses with their edge numbers, a monitor pops them.
`timescale 1ns/1ps
module tb_rx_frame_sync;

    localparam int EV_SYNC = 0;
    localparam int EV_BYTE = 1;
    localparam int EV_ERR  = 2;
    localparam int EV_DONE = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  RX_FS_MAX_ERR;
    logic [15:0] RX_FS_TIMEOUT;
    logic        BPSK;
    logic        PD_flag;
    logic        sync_found, inverted, data_valid, packet_done, frame_err;
    logic [7:0]  frame_len, data_out;

    typedef struct {
        int         kind;
        logic [7:0] val;
        int         edge_n;
    } ev_t;

    ev_t  q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_fail = 0;
    int   last_edge, hunt_edge, k_edge;
    logic flip = 1'b0;

    rx_frame_sync dut (
        .clk(clk), .rst(rst), .RX_FS_MAX_ERR(RX_FS_MAX_ERR), .RX_FS_TIMEOUT(RX_FS_TIMEOUT),
        .BPSK(BPSK), .PD_flag(PD_flag), .sync_found(sync_found), .inverted(inverted),
        .frame_len(frame_len), .data_out(data_out), .data_valid(data_valid),
        .packet_done(packet_done), .frame_err(frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic [7:0] val, input int edge_n);
        ev_t e;
        e.kind = kind; e.val = val; e.edge_n = edge_n;
        q.push_back(e);
    endtask

    task automatic chk_ev(input int kind, input logic [7:0] val);
        ev_t e;
        n_vec++;
        if (q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_pulse: kind %0d val %0h at edge %0d, expected nothing", kind, val, cyc);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || e.val != val || e.edge_n != cyc) begin
                n_fail++;
                $display("FAIL event: got kind %0d val %0h at edge %0d, expected kind %0d val %0h at edge %0d",
                         kind, val, cyc, e.kind, e.val, e.edge_n);
            end
        end
    endtask

    always @(negedge clk) begin
        if (sync_found)  chk_ev(EV_SYNC, {7'b0, inverted});
        if (data_valid)  chk_ev(EV_BYTE, data_out);
        if (frame_err)   chk_ev(EV_ERR, 8'h00);
        if (packet_done) chk_ev(EV_DONE, frame_len);
    end

    task automatic send_bit(input logic b);
        @(negedge clk);
        BPSK = b ^ flip;
        last_edge = cyc + 1;
    endtask

    task automatic send_vec(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic begin_hunt();
        @(negedge clk);
        PD_flag = 1'b1;
        BPSK = 1'b0;
        hunt_edge = cyc + 1;
        last_edge = hunt_edge;
    endtask

    // Preamble, sync word, length byte, then the first npay bits of payload A5 3C FF.
    task automatic send_frame(input logic [31:0] sw, input logic [7:0] len, input int npay,
                              input logic exp_sync, input logic exp_inv);
        logic [23:0] pay;
        pay = 24'hA53CFF;
        begin_hunt();
        send_vec(32'h0000AAAA, 16);
        send_vec(sw, 32);
        k_edge = last_edge;
        if (exp_sync) begin
            push(EV_SYNC, {7'b0, exp_inv}, k_edge);
            for (int n = 1; n <= npay / 8 && n <= int'(len); n++)
                push(EV_BYTE, pay[31 - 8 * n -: 8], k_edge + 8 + 8 * n);
            if (npay / 8 >= int'(len)) push(EV_DONE, len, k_edge + 9 + 8 * int'(len));
        end
        send_vec({24'd0, len}, 8);
        for (int i = 0; i < npay; i++) send_bit(pay[23 - i]);
    endtask

    task automatic finish_frame(input string name);
        @(negedge clk);
        PD_flag = 1'b0;
        repeat (6) @(negedge clk);
        check(name, q.size(), 0);
    endtask

    task automatic timeout_tail(input logic [7:0] held_len, input string name);
        push(EV_ERR, 8'h00, hunt_edge + 101);
        push(EV_DONE, held_len, hunt_edge + 102);
        while (last_edge < hunt_edge + 101) send_bit(1'b0);
        finish_frame(name);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sync_found"}, sync_found, 0);
        check({tag, "_inverted"}, inverted, 0);
        check({tag, "_frame_len"}, frame_len, 0);
        check({tag, "_data_out"}, data_out, 0);
        check({tag, "_data_valid"}, data_valid, 0);
        check({tag, "_packet_done"}, packet_done, 0);
        check({tag, "_frame_err"}, frame_err, 0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; PD_flag = 1'b0; BPSK = 1'b0;
        RX_FS_MAX_ERR = 4'd0; RX_FS_TIMEOUT = 16'd0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Clean frame, exact match
        send_frame(32'h1ACFFC1D, 8'h03, 24, 1'b1, 1'b0);
        finish_frame("clean_drain");
        check("clean_frame_len", frame_len, 8'h03);

        // Two sync bits flipped, tolerance 2
        RX_FS_MAX_ERR = 4'd2;
        send_frame(32'h1ADFFE1D, 8'h03, 24, 1'b1, 1'b0);
        finish_frame("err2_drain");

        // Two sync bits flipped, tolerance 1 -> timeout after 100 hunt cycles
        RX_FS_MAX_ERR = 4'd1; RX_FS_TIMEOUT = 16'd100;
        send_frame(32'h1ADFFE1D, 8'h03, 24, 1'b0, 1'b0);
        timeout_tail(8'h03, "timeout_drain");

        // Fully complemented stream
        RX_FS_MAX_ERR = 4'd0;
        flip = 1'b1;
`ifdef RX_FS_INVERT_EN
        send_frame(32'h1ACFFC1D, 8'h03, 24, 1'b1, 1'b1);
        finish_frame("inv_drain");
        check("inv_held", inverted, 1);
`else
        send_frame(32'h1ACFFC1D, 8'h03, 24, 1'b0, 1'b0);
        timeout_tail(8'h03, "inv_timeout_drain");
`endif
        flip = 1'b0;
        RX_FS_TIMEOUT = 16'd0;

        // Zero length field
        send_frame(32'h1ACFFC1D, 8'h00, 0, 1'b1, 1'b0);
        finish_frame("len0_drain");
        check("len0_frame_len", frame_len, 8'h00);

        // Abort after payload bit 12
        send_frame(32'h1ACFFC1D, 8'h03, 12, 1'b1, 1'b0);
        push(EV_ERR, 8'h00, k_edge + 21);
        finish_frame("abort_drain");
        check("abort_frame_len", frame_len, 8'h03);
        check("abort_data_out", data_out, 8'hA5);

        // Reset in the middle of the payload
        send_frame(32'h1ACFFC1D, 8'h03, 11, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b1; PD_flag = 1'b0;
        @(negedge clk);
        check_all_zero("midrst");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_drain", q.size(), 0);

        // Clean frame after reset
        send_frame(32'h1ACFFC1D, 8'h03, 24, 1'b1, 1'b0);
        finish_frame("post_rst_drain");
        check("post_rst_frame_len", frame_len, 8'h03);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
